// File: rtl/rom_read_arbiter.sv
// Round-robin arbiter sharing one registered-output lookup ROM among NREQ
// requesters; returns tagged data two edges after each grant.
module rom_read_arbiter #(
    parameter int NREQ  = 4,
    parameter int AW    = 10,
    parameter int DW    = 5,
    parameter int DEPTH = 10
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ*AW-1:0]   addr_in,
    output logic [NREQ-1:0]      gnt,
    output logic [NREQ-1:0]      rvalid,
    output logic [DW-1:0]        rdata,
    output logic                 rerr,
    output logic [AW-1:0]        rom_addr,
    input  logic [DW-1:0]        rom_d
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [AW:0] LIMIT = (AW+1)'(DEPTH);

    logic [IW-1:0]   last;
    logic [IW-1:0]   win;
    logic            found;
    logic [NREQ-1:0] elig;
    logic [AW-1:0]   sel_addr;
    logic            sel_err;
    int              idx;

    logic            s1_v, s1_err;
    logic [IW-1:0]   s1_id;
    logic            s2_v, s2_err;
    logic [IW-1:0]   s2_id;

    // A requester already holding gnt this cycle cannot win again.
    assign elig = req & ~gnt;

    always_comb begin
        found = 1'b0;
        win   = '0;
        idx   = 0;
        for (int k = 1; k <= NREQ; k++) begin
            idx = int'(last) + k;
            if (idx >= NREQ) idx = idx - NREQ;
            if (!found && elig[IW'(idx)]) begin
                found = 1'b1;
                win   = IW'(idx);
            end
        end
    end

    assign sel_addr = addr_in[win*AW +: AW];
    assign sel_err  = ({1'b0, sel_addr} >= LIMIT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gnt      <= '0;
            rvalid   <= '0;
            rdata    <= '0;
            rerr     <= 1'b0;
            rom_addr <= '0;
            last     <= IW'(NREQ - 1);
            s1_v     <= 1'b0;
            s1_err   <= 1'b0;
            s1_id    <= '0;
            s2_v     <= 1'b0;
            s2_err   <= 1'b0;
            s2_id    <= '0;
        end else begin
            gnt   <= '0;
            s1_v  <= found;
            s1_id <= win;
            s1_err <= sel_err;
            if (found) begin
                gnt      <= NREQ'(1) << win;
                rom_addr <= sel_addr;
                last     <= win;
            end

            // ROM captures rom_addr on this edge; rom_d is ready one edge later.
            s2_v   <= s1_v;
            s2_id  <= s1_id;
            s2_err <= s1_err;

            rvalid <= '0;
            rerr   <= 1'b0;
            if (s2_v) begin
                rvalid <= NREQ'(1) << s2_id;
                rerr   <= s2_err;
                rdata  <= s2_err ? '0 : rom_d;
            end
        end
    end

endmodule
